// File: rtl/core2wb_bridge.sv
// Core request/grant/rvalid port to pipelined Wishbone B4 master; responses registered (1 cycle after ack/err).
// Grants throttled to MAX_OUTSTANDING in-flight transactions and held off combinationally by wb_stall.
module core2wb_bridge #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  output logic        core_gnt,
  output logic        core_rvalid,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic room, busy, issue, retire;

  // Room is judged on the registered count only, so a slot freed by a retire is reusable next cycle.
  assign room     = (cnt_q < MAX_CNT);
  assign busy     = (cnt_q != '0);
  assign wb_stb   = core_req & room;
  assign core_gnt = wb_stb & ~wb_stall;
  assign wb_cyc   = wb_stb | busy;

  assign wb_we    = core_we;
  assign wb_sel   = core_be;
  assign wb_adr   = core_addr;
  assign wb_dat_o = core_wdata;

  assign issue  = core_gnt;
  // Acks arriving with nothing in flight are stray and must not underflow the count.
  assign retire = (wb_ack | wb_err) & busy;

  always_comb begin
    cnt_d    = cnt_q;
    rvalid_d = retire;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (issue && !retire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (retire && !issue) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (retire) begin
      rdata_d = wb_dat_i;
      err_d   = wb_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign core_err    = err_q;

endmodule

// File: tb/tb_core2wb_bridge.sv
// Bench for core2wb_bridge: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-count model of the bridge.
module tb_core2wb_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_gnt;
  logic        core_rvalid;
  logic        core_we = 1'b0;
  logic [3:0]  core_be = 4'h0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        wb_stall = 1'b0;

  always #5 clk = ~clk;

  core2wb_bridge #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_we(core_we), .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: number of accepted-but-unanswered transactions plus the last response.
  int          m_out = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = 0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
    end else begin
      bit accepted, answered;
      accepted = core_req && (m_out < MAX) && !wb_stall;
      answered = (wb_ack || wb_err) && (m_out > 0);
      m_rvalid = answered;
      if (answered) begin
        m_rdata = wb_dat_i;
        m_err   = wb_err;
      end
      m_out = m_out + int'(accepted) - int'(answered);
    end
  end

  always @(negedge clk) begin
    bit e_stb;
    e_stb = core_req && (m_out < MAX);
    chk("wb_stb", wb_stb, e_stb);
    chk("core_gnt", core_gnt, e_stb && !wb_stall);
    chk("wb_cyc", wb_cyc, e_stb || (m_out > 0));
    chk("core_rvalid", core_rvalid, m_rvalid);
    chk("core_rdata", core_rdata, m_rdata);
    chk("core_err", core_err, m_err);
    if (e_stb) begin
      chk("wb_adr", wb_adr, core_addr);
      chk("wb_dat_o", wb_dat_o, core_wdata);
      chk("wb_sel", wb_sel, core_be);
      chk("wb_we", wb_we, core_we);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = '0;
  endtask

  // Request list for bus_run; slave answers each grant lat cycles later with dat = addr + 0x100.
  logic [31:0] ra[$];
  int          err_idx = -1;
  int          gnt_cyc[$];
  logic [31:0] rv_dat[$];
  logic        rv_err[$];

  task automatic bus_run(input int lat, input int limit);
    logic [31:0] pa[$];
    int pd[$];
    int pi[$];
    int issued;
    int cyc;
    issued = 0; cyc = 0;
    gnt_cyc.delete(); rv_dat.delete(); rv_err.delete();
    while ((issued < ra.size() || pa.size() > 0) && cyc < limit) begin
      tick();
      core_req = (issued < ra.size());
      if (core_req) begin
        core_addr = ra[issued]; core_we = 1'b0; core_be = 4'hF; core_wdata = ~ra[issued];
      end
      wb_stall = 1'b0;
      if (pa.size() > 0 && pd[0] <= cyc) begin
        wb_ack = 1'b1; wb_dat_i = pa[0] + 32'h100; wb_err = (pi[0] == err_idx);
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
      end
      @(negedge clk);
      if (core_rvalid) begin rv_dat.push_back(core_rdata); rv_err.push_back(core_err); end
      if (wb_ack) begin void'(pa.pop_front()); void'(pd.pop_front()); void'(pi.pop_front()); end
      if (core_gnt) begin
        gnt_cyc.push_back(cyc); pa.push_back(ra[issued]); pd.push_back(cyc + lat); pi.push_back(issued);
        issued++;
      end
      cyc++;
    end
    chk("bus_run_in_time", cyc < limit, 1);
    tick(); idle_inputs();
    @(negedge clk);
    if (core_rvalid) begin rv_dat.push_back(core_rdata); rv_err.push_back(core_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_rvalid", core_rvalid, 0); chk("rst_rdata", core_rdata, 0);
    chk("rst_err", core_err, 0); chk("rst_cyc", wb_cyc, 0); chk("rst_stb", wb_stb, 0);
    tick(); rst = 1'b0;
    tick();

    // Single read, slave acks one cycle after strobe
    tick(); core_req = 1'b1; core_addr = 32'h0000_1000; core_be = 4'hF; core_we = 1'b0;
    @(negedge clk); chk("rd_gnt_c0", core_gnt, 1); chk("rd_cyc_c0", wb_cyc, 1);
    tick(); core_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    @(negedge clk); chk("rd_cyc_c1", wb_cyc, 1); chk("rd_rvalid_c1", core_rvalid, 0);
    tick(); idle_inputs();
    @(negedge clk); chk("rd_rvalid_c2", core_rvalid, 1); chk("rd_rdata_c2", core_rdata, 32'hDEAD_BEEF);
    chk("rd_err_c2", core_err, 0); chk("rd_cyc_c2", wb_cyc, 0);

    // Single write, stalled three cycles
    for (int c = 0; c < 4; c++) begin
      tick(); core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h1234_5678;
      core_be = 4'h3; wb_stall = (c < 3);
      @(negedge clk); chk("wr_gnt", core_gnt, (c == 3)); chk("wr_sel", wb_sel, 4'h3);
    end
    tick(); idle_inputs(); wb_ack = 1'b1; wb_dat_i = 32'h0;
    @(negedge clk); chk("wr_rvalid_ack", core_rvalid, 0);
    tick(); idle_inputs();
    @(negedge clk); chk("wr_rvalid", core_rvalid, 1); chk("wr_err", core_err, 0);
    tick();
    @(negedge clk); chk("wr_rvalid_once", core_rvalid, 0);

    // Throttle: request held, acks five cycles after each grant
    ra = '{32'h100, 32'h104, 32'h108, 32'h10C}; err_idx = -1;
    bus_run(5, 60);
    chk("thr_ngnt", gnt_cyc.size(), 4);
    chk("thr_g0", gnt_cyc[0], 0); chk("thr_g1", gnt_cyc[1], 1);
    chk("thr_g2", gnt_cyc[2], 6); chk("thr_g3", gnt_cyc[3], 7);
    chk("thr_nrv", rv_dat.size(), 4);

    // Back-to-back pipelined reads
    ra = '{32'h0, 32'h4, 32'h8, 32'hC};
    bus_run(1, 40);
    chk("b2b_nrv", rv_dat.size(), 4);
    chk("b2b_d0", rv_dat[0], 32'h100); chk("b2b_d1", rv_dat[1], 32'h104);
    chk("b2b_d2", rv_dat[2], 32'h108); chk("b2b_d3", rv_dat[3], 32'h10C);

    // Error on the 2nd transaction, coinciding with the 3rd grant
    ra = '{32'h40, 32'h44, 32'h48}; err_idx = 1;
    bus_run(1, 40);
    chk("err_nrv", rv_err.size(), 3);
    chk("err_e0", rv_err[0], 0); chk("err_e1", rv_err[1], 1); chk("err_e2", rv_err[2], 0);
    chk("err_d2", rv_dat[2], 32'h148); chk("err_g2", gnt_cyc[2], 2);
    err_idx = -1;

    // Reset with two in flight, then a stray ack
    tick(); core_req = 1'b1; core_addr = 32'h80; core_be = 4'hF;
    tick(); core_addr = 32'h84;
    tick(); core_req = 1'b0;
    @(negedge clk); chk("rs_cyc_busy", wb_cyc, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("rs_cyc_async", wb_cyc, 0); chk("rs_rvalid_async", core_rvalid, 0);
    tick(); tick(); rst = 1'b0;
    tick(); wb_ack = 1'b1; wb_dat_i = 32'h0BAD_0BAD;
    tick(); idle_inputs();
    @(negedge clk); chk("rs_stray_rvalid", core_rvalid, 0); chk("rs_cyc", wb_cyc, 0);
    chk("rs_rdata", core_rdata, 0);
    tick();
    @(negedge clk); chk("rs_stray_rvalid2", core_rvalid, 0);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 2000; i++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      core_req   = ($urandom_range(0, 9) < 6);
      core_we    = 1'($urandom_range(0, 1));
      core_be    = 4'($urandom);
      core_addr  = $urandom;
      core_wdata = $urandom;
      wb_stall   = ($urandom_range(0, 9) < 3);
      wb_ack     = ($urandom_range(0, 9) < 4);
      wb_err     = ($urandom_range(0, 9) == 0);
      wb_dat_i   = $urandom;
    end
    tick(); rst = 1'b0; idle_inputs();
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
